// File: rtl/jdrosent_debounce_sync.sv
// Two-flop synchroniser plus counter debounce for one raw button line.
// Define DEBOUNCE_EVENT_COUNT_EN to drive a 4-bit press count on io_out[7:4].
module jdrosent_debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {
    IDLE,
    CHECK
  } state_t;

  logic clk;
  logic rst_n;
  logic raw;
  logic unused_in;

  assign clk       = io_in[0];
  assign rst_n     = io_in[1];
  assign raw       = io_in[2];
  assign unused_in = ^io_in[7:3];

  logic          s1;
  logic          s;
  logic          clean;
  logic          clean_d;
  logic          glitch;
  logic          glitch_d;
  logic          rise;
  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      clean  <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      clean  <= clean_d;
      glitch <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    clean_d  = clean;
    glitch_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (s != clean) begin
          state_d = CHECK;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      CHECK: begin
        if (s == clean) begin
          state_d  = IDLE;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt == CMAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          clean_d = s;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rise = ~clean & clean_d;

  assign io_out[0] = clean;
  assign io_out[1] = (state == CHECK);
  assign io_out[2] = s;
  assign io_out[3] = glitch;

`ifdef DEBOUNCE_EVENT_COUNT_EN
  logic [3:0] evt;

  // Counts in the same edge clean rises; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt <= 4'd0;
    end else if (rise) begin
      evt <= evt + 4'd1;
    end
  end

  assign io_out[7:4] = evt;
`else
  logic unused_rise;

  assign unused_rise = rise;
  assign io_out[7:4] = 4'b0000;
`endif

endmodule

// File: tb/tb_jdrosent_debounce_sync.sv
// Scoreboard bench for jdrosent_debounce_sync at DEBOUNCE_CYCLES = 8.
// Honours DEBOUNCE_EVENT_COUNT_EN for the expected io_out[7:4].
module tb_jdrosent_debounce_sync;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       raw = 1'b0;
  logic [4:0] junk = 5'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {junk, raw, rst_n, clk};

  jdrosent_debounce_sync #(.DEBOUNCE_CYCLES(D)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int gl_seen  = 0;

  logic [7:0] exp_q[$];

  logic       m_s1, m_s, m_clean, m_chk, m_gl;
  int         m_cnt;
  logic [3:0] m_evt;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_s1 = 0; m_s = 0; m_clean = 0; m_chk = 0; m_gl = 0;
    m_cnt = 0; m_evt = 0;
  endtask

  // Reference: run length of the synchronised level differing from clean.
  task automatic m_step();
    logic s_old;
    s_old = m_s;
    m_gl  = 0;
    if (!m_chk) begin
      if (s_old != m_clean) begin
        m_chk = 1;
        m_cnt = 1;
      end
    end else if (s_old == m_clean) begin
      m_chk = 0;
      m_cnt = 0;
      m_gl  = 1;
    end else if (m_cnt >= D) begin
      if (s_old) m_evt = m_evt + 4'd1;
      m_clean = s_old;
      m_chk   = 0;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
    m_s  = m_s1;
    m_s1 = raw;
  endtask

  function automatic logic [7:0] m_out();
    logic [3:0] e;
`ifdef DEBOUNCE_EVENT_COUNT_EN
    e = m_evt;
`else
    e = 4'd0;
`endif
    return {e, m_gl, m_s, m_chk, m_clean};
  endfunction

  task automatic cyc(input logic r);
    logic [7:0] e;
    raw  = r;
    junk = 5'($urandom);
    @(posedge clk);
    m_step();
    exp_q.push_back(m_out());
    #1;
    e = exp_q.pop_front();
    chk("cycle", io_out, e);
    if (io_out[3]) gl_seen++;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_async", io_out, 8'h00);
    @(negedge clk);
    chk("rst_hold", io_out, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic latency_press(input string tag);
    for (int k = 0; k < 14; k++) begin
      cyc(1'b1);
      if (k == 1) chk({tag, "_busy1"}, {7'd0, io_out[1]}, 8'd0);
      if (k == 2) chk({tag, "_busy2"}, {7'd0, io_out[1]}, 8'd1);
      if (k == 9) chk({tag, "_clean9"}, {6'd0, io_out[1:0]}, 8'd2);
      if (k == 10) chk({tag, "_clean10"}, {6'd0, io_out[1:0]}, 8'd1);
    end
  endtask

  initial begin
    logic [3:0] evt0;
    int         g0;
    int         w;
    m_reset();
    raw = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_init", io_out, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("rst_init_hold", io_out, 8'h00);
    rst_n = 1'b1;
    latency_press("boot");

    evt0 = io_out[7:4];
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0);
      if (k == 9) chk("rel_clean9", {7'd0, io_out[0]}, 8'd1);
      if (k == 10) chk("rel_clean10", {7'd0, io_out[0]}, 8'd0);
    end
    chk("rel_evt", {4'd0, io_out[7:4]}, {4'd0, evt0});

    g0 = gl_seen;
    latency_press("press");
    for (int k = 0; k < 6; k++) cyc(1'b1);
    for (int k = 0; k < 14; k++) cyc(1'b0);
    chk("press_noglitch", 8'(gl_seen - g0), 8'd0);

    g0 = gl_seen;
    for (int k = 0; k < 4; k++) cyc(1'b1);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0);
      if (k == 0) chk("bounce_busy", {7'd0, io_out[1]}, 8'd1);
    end
    chk("bounce_gl", 8'(gl_seen - g0), 8'd1);
    chk("bounce_clean", {7'd0, io_out[0]}, 8'd0);

    g0 = gl_seen;
    for (int p = 0; p < 10; p++) begin
      w = $urandom_range(1, D);
      for (int k = 0; k < w; k++) cyc(1'b1);
      w = $urandom_range(1, 3);
      for (int k = 0; k < w; k++) cyc(1'b0);
    end
    for (int k = 0; k < 12; k++) cyc(1'b0);
    chk("short_clean", {7'd0, io_out[0]}, 8'd0);
    chk("short_gl", 8'(gl_seen > g0), 8'd1);

    evt0 = io_out[7:4];
    for (int p = 0; p < 17; p++) begin
      for (int k = 0; k < 12; k++) cyc(1'b1);
      for (int k = 0; k < 12; k++) cyc(1'b0);
    end
`ifdef DEBOUNCE_EVENT_COUNT_EN
    chk("wrap_evt", {4'd0, io_out[7:4]}, {4'd0, 4'(evt0 + 4'd1)});
`else
    chk("wrap_evt", {4'd0, io_out[7:4]}, 8'd0);
`endif

    for (int k = 0; k < 7; k++) cyc(1'b1);
    chk("mid_busy", {7'd0, io_out[1]}, 8'd1);
    g0 = gl_seen;
    async_reset();
    latency_press("mid");
    chk("mid_noglitch", 8'(gl_seen - g0), 8'd0);

    for (int k = 0; k < 200; k++) cyc($urandom_range(0, 3) != 0 ? raw : ~raw);
    for (int k = 0; k < 20; k++) cyc(1'b0);
    chk("q_empty", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
